cw_read_sched: RTL and testbench

Scheduler that sequences beam-codeword readout from the codeword table for the PUSCH dimension-reduction datapath. Per symbol it accepts a start command, waits until the codeword table is valid, and selects a bank (even/odd). It then issues a valid/ready-handshaked stream of table addresses 0..N-1, one per cycle at full throughput, and pulses done. It sits between the symbol-timing control and the beamforming multiplier's codeword port.

---
 rtl/cw_read_sched_if.sv | 30 +++
 rtl/cw_read_sched.sv | 101 ++++++++++
 tb/tb_cw_read_sched.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cw_read_sched_if.sv
// Handshake bundle between the symbol-timing control, the codeword read
// scheduler and the beamforming multiplier's codeword port.
interface cw_read_sched_if #(
  parameter int DEPTH = 64
) ();
  localparam int AW = $clog2(DEPTH);

  logic          i_cw_tvalid;
  logic          i_start;
  logic          i_bank;
  logic [AW:0]   i_num_beams;
  logic          i_ready;
  logic [AW-1:0] o_cw_addr;
  logic          o_cw_sel;
  logic          o_valid;
  logic          o_last;
  logic          o_busy;
  logic          o_done;
  logic          o_err;

  modport master (
    output i_cw_tvalid, i_start, i_bank, i_num_beams, i_ready,
    input  o_cw_addr, o_cw_sel, o_valid, o_last, o_busy, o_done, o_err
  );

  modport slave (
    input  i_cw_tvalid, i_start, i_bank, i_num_beams, i_ready,
    output o_cw_addr, o_cw_sel, o_valid, o_last, o_busy, o_done, o_err
  );
endinterface

// File: rtl/cw_read_sched.sv
// Per-symbol codeword read scheduler: waits for a valid codeword table, then
// streams table addresses 0..N-1 over valid/ready and pulses done.
module cw_read_sched #(
  parameter int DEPTH = 64
) (
  input  logic                i_clk,
  input  logic                i_reset,
  cw_read_sched_if.slave      bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE     = (AW+1)'(1);
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT_TBL, RUN, DONE} state_t;

  state_t      state, state_nxt;
  logic [AW:0] addr_q, addr_nxt;
  logic [AW:0] count_q, count_nxt;
  logic        bank_q, bank_nxt;
  logic        err_pend_q, err_pend_nxt;
  logic        valid_nxt, last_nxt, busy_nxt, done_nxt, err_nxt;
  logic        legal, accept, handshake, last_beat, err_now;

  assign legal     = (bus.i_num_beams != '0) && (bus.i_num_beams <= DEPTH_W);
  assign accept    = (state == IDLE) && bus.i_start && legal;
  assign handshake = (state == RUN) && bus.i_ready;
  assign last_beat = (addr_q == count_q - ONE);

  // State register plus all registered outputs.
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (i_reset) begin
      state       <= IDLE;
      addr_q      <= '0;
      count_q     <= '0;
      bank_q      <= 1'b0;
      err_pend_q  <= 1'b0;
      bus.o_valid <= 1'b0;
      bus.o_last  <= 1'b0;
      bus.o_busy  <= 1'b0;
      bus.o_done  <= 1'b0;
      bus.o_err   <= 1'b0;
    end else begin
      state       <= state_nxt;
      addr_q      <= addr_nxt;
      count_q     <= count_nxt;
      bank_q      <= bank_nxt;
      err_pend_q  <= err_pend_nxt;
      bus.o_valid <= valid_nxt;
      bus.o_last  <= last_nxt;
      bus.o_busy  <= busy_nxt;
      bus.o_done  <= done_nxt;
      bus.o_err   <= err_nxt;
    end
  end

  assign bus.o_cw_addr = addr_q[AW-1:0];
  assign bus.o_cw_sel  = bank_q;

  always_comb begin
    // NOTE: default first so every path assigns state_nxt and no latch forms.
    state_nxt = state;
    unique case (state)
      IDLE:     if (accept) state_nxt = bus.i_cw_tvalid ? RUN : WAIT_TBL;
      WAIT_TBL: if (bus.i_cw_tvalid) state_nxt = RUN;
      RUN: begin
        if (!bus.i_cw_tvalid)            state_nxt = IDLE;
        else if (handshake && last_beat) state_nxt = DONE;
      end
      DONE:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Next values of the datapath and the registered outputs.
  always_comb begin
    addr_nxt  = addr_q;
    count_nxt = count_q;
    bank_nxt  = bank_q;
    if (accept) begin
      addr_nxt  = '0;
      count_nxt = bus.i_num_beams;
      bank_nxt  = bus.i_bank;
    end else if (handshake && bus.i_cw_tvalid && !last_beat) begin
      addr_nxt  = addr_q + ONE;
    end

    valid_nxt = (state_nxt == RUN);
    busy_nxt  = (state_nxt != IDLE);
    done_nxt  = (state_nxt == DONE);
    last_nxt  = valid_nxt && (addr_nxt == count_nxt - ONE);

    // An error that coincides with the done pulse is held back one cycle so
    // done and err never overlap; coincident errors merge into one pulse.
    err_now      = (bus.i_start && ((state != IDLE) || !legal)) ||
                   ((state == RUN) && !bus.i_cw_tvalid);
    err_nxt      = (err_now || err_pend_q) && !done_nxt;
    err_pend_nxt = (err_now || err_pend_q) && done_nxt;
  end
endmodule

// File: tb/tb_cw_read_sched.sv
// Scoreboard bench for cw_read_sched: stimulus pushes expected beats/events,
// a negedge monitor pops and compares whatever the DUT presents.
module tb_cw_read_sched;
  localparam int DEPTH = 64;

  typedef struct packed {
    logic [5:0] addr;
    logic       sel;
    logic       last;
  } beat_t;

  typedef enum int {EV_DONE, EV_ERR} ev_t;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  beat_t beat_q[$];
  ev_t   ev_q[$];

  cw_read_sched_if #(.DEPTH(DEPTH)) bus ();

  cw_read_sched #(.DEPTH(DEPTH)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor / scoreboard
  logic  stall_q = 1'b0;
  beat_t held_b;
  beat_t exp_b;
  beat_t obs_b;
  ev_t   exp_ev;
  ev_t   obs_ev;

  always @(negedge clk) begin
    obs_b = {bus.o_cw_addr, bus.o_cw_sel, bus.o_last};
    if (bus.o_valid && bus.i_ready) begin
      if (beat_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL beat_unexpected: got beat 0x%0h, expected none at %0t", obs_b, $time);
      end else begin
        exp_b = beat_q.pop_front();
        check("beat", 32'(obs_b), 32'(exp_b));
      end
    end
    if (stall_q && bus.o_valid)
      check("stall_hold", 32'(obs_b), 32'(held_b));
    stall_q = bus.o_valid && !bus.i_ready && !rst;
    held_b  = obs_b;

    if (bus.o_done || bus.o_err) begin
      check("done_err_exclusive", 32'(bus.o_done & bus.o_err), 32'd0);
      obs_ev = bus.o_done ? EV_DONE : EV_ERR;
      if (ev_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL event_unexpected: got %s, expected none at %0t", obs_ev.name(), $time);
      end else begin
        exp_ev = ev_q.pop_front();
        check("event_kind", 32'(obs_ev), 32'(exp_ev));
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_addr"},  32'(bus.o_cw_addr), 32'd0);
    check({tag, "_sel"},   32'(bus.o_cw_sel),  32'd0);
    check({tag, "_valid"}, 32'(bus.o_valid),   32'd0);
    check({tag, "_last"},  32'(bus.o_last),    32'd0);
    check({tag, "_busy"},  32'(bus.o_busy),    32'd0);
    check({tag, "_done"},  32'(bus.o_done),    32'd0);
    check({tag, "_err"},   32'(bus.o_err),     32'd0);
  endtask

  task automatic push_beats(input logic bank, input int n, input int upto, input bit with_last);
    beat_t b;
    for (int k = 0; k < upto; k++) begin
      b.addr = 6'(k);
      b.sel  = bank;
      b.last = with_last && (k == n - 1);
      beat_q.push_back(b);
    end
  endtask

  // Full symbol; rdy_pat[c-1] is i_ready in cycle c after the start edge,
  // tv_wait cycles of i_cw_tvalid=0 follow the start when nonzero.
  task automatic run_sym(input logic bank, input int n, input logic [15:0] rdy_pat,
                         input int pat_len, input int tv_wait, input int exp_lat);
    int lat;
    bit seen;
    push_beats(bank, n, n, 1'b1);
    ev_q.push_back(EV_DONE);
    bus.i_bank      = bank;
    bus.i_num_beams = 7'(n);
    bus.i_cw_tvalid = (tv_wait == 0);
    bus.i_start     = 1'b1;
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    lat  = 0;
    seen = 1'b0;
    for (int c = 1; c <= n + 64 && !seen; c++) begin
      bus.i_ready = (c <= pat_len) ? rdy_pat[c-1] : 1'b1;
      if (c > tv_wait) bus.i_cw_tvalid = 1'b1;
      @(negedge clk);
      if (c == 1 || (tv_wait > 0 && c <= tv_wait + 1))
        check("busy_while_active", 32'(bus.o_busy), 32'd1);
      if (tv_wait > 0 && c <= tv_wait + 1)
        check("valid_while_waiting", 32'(bus.o_valid), 32'd0);
      if (bus.o_done) begin
        seen = 1'b1;
        lat  = c;
      end else begin
        @(posedge clk); #1;
      end
    end
    check("done_latency", 32'(lat), 32'(exp_lat));
    @(posedge clk); #1;
    bus.i_ready = 1'b1;
    @(negedge clk);
    check("busy_cleared", 32'(bus.o_busy), 32'd0);
  endtask

  task automatic bad_start(input int n);
    ev_q.push_back(EV_ERR);
    bus.i_num_beams = 7'(n);
    bus.i_start     = 1'b1;
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("bad_start_busy",  32'(bus.o_busy),  32'd0);
      check("bad_start_valid", 32'(bus.o_valid), 32'd0);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst             = 1'b1;
    bus.i_start     = 1'b0;
    bus.i_bank      = 1'b0;
    bus.i_num_beams = '0;
    bus.i_ready     = 1'b1;
    bus.i_cw_tvalid = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Full-depth symbol, odd bank: done 65 cycles after the start edge.
    run_sym(1'b1, 64, 16'h0000, 0, 0, 65);

    // Stalls: ready 1,0,0,1,1,0,1 -> done in cycle 8.
    run_sym(1'b0, 4, 16'b0000_0000_0101_1001, 7, 0, 8);

    // Table not valid for 5 cycles: 3 beats, done in cycle 3+1+6.
    run_sym(1'b1, 3, 16'h0000, 0, 5, 10);

    // Single-beat symbol.
    run_sym(1'b0, 1, 16'h0000, 0, 0, 2);
    @(posedge clk); #1;

    // Illegal counts.
    bad_start(0);
    bad_start(65);

    // 16-beat run: extra start at beat 2, table drop at beat 5.
    push_beats(1'b1, 16, 6, 1'b0);
    ev_q.push_back(EV_ERR);
    ev_q.push_back(EV_ERR);
    bus.i_bank      = 1'b1;
    bus.i_num_beams = 7'd16;
    bus.i_cw_tvalid = 1'b1;
    bus.i_start     = 1'b1;
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      if (c == 3) begin
        bus.i_start     = 1'b1;
        bus.i_bank      = 1'b0;
        bus.i_num_beams = 7'd5;
      end else begin
        bus.i_start = 1'b0;
      end
      if (c == 6) bus.i_cw_tvalid = 1'b0;
      @(negedge clk);
      if (c == 5) check("sel_unchanged", 32'(bus.o_cw_sel), 32'd1);
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("drop_valid_low", 32'(bus.o_valid), 32'd0);
    check("drop_err",       32'(bus.o_err),   32'd1);
    @(posedge clk); #1;
    bus.i_cw_tvalid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("drop_idle_busy", 32'(bus.o_busy), 32'd0);
    end
    @(posedge clk); #1;

    // Reset at beat 10 of 32.
    push_beats(1'b1, 32, 11, 1'b0);
    bus.i_bank      = 1'b1;
    bus.i_num_beams = 7'd32;
    bus.i_start     = 1'b1;
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("pre_reset_addr", 32'(bus.o_cw_addr), 32'd10);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("mid_run_reset");
    @(posedge clk); #1;
    run_sym(1'b0, 2, 16'h0000, 0, 0, 3);

    repeat (4) @(negedge clk);
    check("beat_queue_drained",  32'(beat_q.size()), 32'd0);
    check("event_queue_drained", 32'(ev_q.size()),   32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
